// File: rtl/spcore_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spcore_mem_arbiter: round-robin sharing of one data memory among N cores  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spcore_mem_arbiter #(
  parameter int N  = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr_in,
  input  logic [N*DW-1:0] wdata_in,
  output logic [N-1:0]    done,
  output logic [DW-1:0]   rdata,
  output logic [N-1:0]    core_en,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int         c_IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;
  localparam logic [N-1:0] c_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [c_IW-1:0] r_last;
  logic [c_IW-1:0] r_win;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [N-1:0]    r_done;
  logic [DW-1:0]   r_rdata;
  logic [N-1:0]    w_elig;
  logic            w_grant_vld;
  logic [c_IW-1:0] w_grant_idx;

  // A core is ineligible in its own done cycle so a held req is not re-served.
  assign w_elig = req & ~r_done;

  // Scan downwards so the candidate closest to last+1 is the one that sticks.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (w_elig[c_IW'((int'(r_last) + k) % N)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = c_IW'((int'(r_last) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (w_grant_vld) w_next = c_ACCESS;
      c_ACCESS: w_next = c_RESP;
      c_RESP:   w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_re = 1'b0;
    if (r_state == c_ACCESS) begin
      mem_we = r_we;
      mem_re = ~r_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last  <= c_IW'(N - 1);
      r_win   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= '0;
      r_rdata <= '0;
    end else begin
      r_done <= '0;
      if (r_state == c_IDLE && w_grant_vld) begin
        r_last  <= w_grant_idx;
        r_win   <= w_grant_idx;
        r_we    <= we[w_grant_idx];
        r_addr  <= addr_in[w_grant_idx*AW +: AW];
        r_wdata <= wdata_in[w_grant_idx*DW +: DW];
      end
      if (r_state == c_RESP) begin
        r_done <= c_ONE << r_win;
        if (!r_we) r_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign core_en   = ~req | r_done;

endmodule
`default_nettype wire

// File: tb/tb_spcore_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spcore_mem_arbiter: directed + random bench with a transaction model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_spcore_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] wdata_in;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic [N-1:0]    core_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic            mem_re;
  logic [DW-1:0]   mem_rdata;

  spcore_mem_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr_in(addr_in),
    .wdata_in(wdata_in), .done(done), .rdata(rdata), .core_en(core_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a, ~a} ^ 16'h3C5A;
  endfunction

  // Synchronous single-port memory: read data one cycle after mem_re.
  logic [DW-1:0] sim_mem [256];
  bit            sim_wr  [256];
  always @(posedge clk) begin
    if (mem_we) begin
      sim_mem[mem_addr[7:0]] <= mem_wdata;
      sim_wr[mem_addr[7:0]]  <= 1'b1;
    end
    if (mem_re)
      mem_rdata <= sim_wr[mem_addr[7:0]] ? sim_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  end

  // Reference model: memory contents, last-served core, last load data.
  logic [DW-1:0] ref_mem [256];
  bit            ref_wr  [256];
  int            model_last;
  logic [DW-1:0] model_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [N-1:0]  s_we;
  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_wd   [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [7:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  // All cores in m raise req together from an idle arbiter and each holds
  // until its done; service order is m rotated to start after model_last.
  task automatic run_batch(input logic [N-1:0] m);
    int            order[$];
    logic [N-1:0]  exp_done;
    logic [N-1:0]  exp_en;
    logic [N-1:0]  drop;
    logic [1:0]    exp_st;
    int            c;
    for (int k = 1; k <= N; k++) begin
      c = (model_last + k) % N;
      if (m[c]) order.push_back(c);
    end
    if (order.size() > 0) model_last = order[order.size()-1];
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      we[i] = s_we[i];
      addr_in[i*AW +: AW]  = s_addr[i];
      wdata_in[i*DW +: DW] = s_wd[i];
    end
    req  = m;
    drop = '0;
    for (int cyc = 1; cyc <= 3*order.size() + 2; cyc++) begin
      @(posedge clk); #1;
      req  = req & ~drop;
      drop = '0;
      @(negedge clk);
      exp_done = '0;
      exp_st   = 2'b00;
      for (int j = 0; j < order.size(); j++) begin
        if (cyc == 1 + 3*j) begin
          exp_st = s_we[order[j]] ? 2'b10 : 2'b01;
          chk("mem_addr", mem_addr, s_addr[order[j]]);
          if (s_we[order[j]]) chk("mem_wdata", mem_wdata, s_wd[order[j]]);
        end
        if (cyc == 3 + 3*j) begin
          exp_done[order[j]] = 1'b1;
          if (s_we[order[j]]) begin
            ref_mem[s_addr[order[j]][7:0]] = s_wd[order[j]];
            ref_wr[s_addr[order[j]][7:0]]  = 1'b1;
          end else begin
            model_rdata = ref_read(s_addr[order[j]][7:0]);
          end
        end
      end
      exp_en = ~req | exp_done;
      chk("done", done, exp_done);
      chk("strobes", {mem_we, mem_re}, exp_st);
      chk("rdata", rdata, model_rdata);
      chk("core_en", core_en, exp_en);
      drop = exp_done;
    end
  endtask

  initial begin
    reset = 1'b0; req = '0; we = '0; addr_in = '0; wdata_in = '0;
    model_last = N - 1; model_rdata = '0;
    s_we = '0;
    for (int i = 0; i < N; i++) begin s_addr[i] = '0; s_wd[i] = '0; end

    // Reset with all requests raised
    req = 4'b1111;
    #12;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strobes", {mem_we, mem_re}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_en", core_en, 4'b0000);
    req = '0;
    @(posedge clk); #1 reset = 1'b1;

    // Contention: first grant to core 0, then 1,2,3
    for (int i = 0; i < N; i++) begin s_we[i] = 1'b0; s_addr[i] = 16'(8'h40 + i); end
    run_batch(4'b1111);

    // Single load of 0xBEEF by core 2
    s_we[2] = 1'b0; s_addr[2] = 16'h0010;
    run_batch(4'b0100);

    // Single store by core 1; rdata must keep 0xBEEF
    s_we[1] = 1'b1; s_addr[1] = 16'h0020; s_wd[1] = 16'h1234;
    run_batch(4'b0010);

    // Fairness wrap: core 3 served, then 0 beats 3
    s_we[3] = 1'b0; s_addr[3] = 16'h0020;
    run_batch(4'b1000);
    s_we[0] = 1'b1; s_addr[0] = 16'h0020; s_wd[0] = 16'hA5A5;
    run_batch(4'b1001);

    // Reset during ACCESS of a store
    s_we[1] = 1'b1; s_addr[1] = 16'h0030; s_wd[1] = 16'h5555;
    @(posedge clk); #1;
    we[1] = 1'b1; addr_in[1*AW +: AW] = s_addr[1]; wdata_in[1*DW +: DW] = s_wd[1];
    req = 4'b0010;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_we_before", mem_we, 1);
    #1 reset = 1'b0;
    #1;
    chk("abort_we_drop", mem_we, 0);
    chk("abort_re", mem_re, 0);
    chk("abort_done", done, 0);
    req = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_done_hold", done, 0);
      chk("abort_we_hold", mem_we, 0);
    end
    @(posedge clk); #1 reset = 1'b1;
    model_last = N - 1; model_rdata = '0;
    @(negedge clk);
    chk("post_abort_done", done, 0);
    chk("post_abort_rdata", rdata, 0);
    chk("post_abort_strobes", {mem_we, mem_re}, 0);
    s_we[1] = 1'b0; s_addr[1] = 16'h0020; s_we[3] = 1'b0; s_addr[3] = 16'h0010;
    run_batch(4'b1010);

    // Randomized batches over a small address window to force RAW hazards
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) begin
        s_we[i]   = 1'($urandom_range(0, 1));
        s_addr[i] = 16'($urandom_range(0, 31));
        s_wd[i]   = 16'($urandom);
      end
      run_batch(4'($urandom_range(1, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spcore_mem_arbiter.md
# spcore_mem_arbiter

Round-robin arbiter that shares one single-port data memory among `N` SP cores. Each core presents a load/store request on its `data_out`/`addr` lines; the arbiter serializes them onto the memory port, returns read data for the core's `data_in`, and holds each waiting core's clock enable low until its access completes. It sits between the core array and the shared data memory.

## Interface
- `N`, 4: number of SP cores (requesters), 2..8
- `AW`, 16: address width
- `DW`, 16: data width
- `clk` input 1: single clock, rising-edge
- `reset` input 1: asynchronous, active-low reset
- `req` input N: per-core access request (level)
- `we` input N: per-core write select (1 = store, 0 = load), valid with `req`
- `addr_in` input N*AW: per-core address, core i at bits [i*AW +: AW]
- `wdata_in` input N*DW: per-core store data, same packing
- `done` output N: one-hot, one-cycle completion pulse
- `rdata` output DW: load data, valid in the `done` cycle
- `core_en` output N: core enable to each spcore `en`
- `mem_addr` output AW: memory address
- `mem_wdata` output DW: memory write data
- `mem_we` output 1: memory write strobe
- `mem_re` output 1: memory read strobe
- `mem_rdata` input DW: memory read data, one cycle after `mem_re`

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: eligible set = `req & ~done`. If non-empty, select winner by round-robin, latch winner index, `we`, `addr_in`, `wdata_in` slice; go to ACCESS. Otherwise stay.
- Round-robin: search starts at `(last + 1) mod N`, ascending with wrap; `last` updates to the winner on grant. `last` resets to N-1, so core 0 has top priority after reset.
- ACCESS: drive latched address/data; `mem_we` = latched we, `mem_re` = ~latched we; go to RESP. Strobes are 0 in all other states.
- RESP: register `rdata <= mem_rdata` (loads only; stores leave `rdata` unchanged), register `done <= onehot(winner)`; go to IDLE.
- `done` is registered and high for exactly one cycle (the cycle after RESP). During that cycle the FSM is in IDLE and excludes that core from arbitration.
- Requester protocol: hold `req`, `we`, `addr_in`, `wdata_in` stable from assertion until the `done` cycle. If `req` is still high in the cycle after `done`, it is a new request.
- `core_en[i] = ~req[i] | done[i]` (combinational): core clock is gated while it waits.
- Requests arriving during ACCESS/RESP wait; no request is ever dropped.
- Reset values: state IDLE, `done` 0, `rdata` 0, `last` N-1, latched registers 0, `mem_we`/`mem_re` 0, `mem_addr`/`mem_wdata` 0.
- Reset mid-operation aborts the transaction immediately: no `done`, strobes drop asynchronously, and the aborted write is not guaranteed.

## Timing
- A request seen in IDLE at cycle 0 is on the memory port in cycle 1. Memory data is valid in cycle 2. `done` and `rdata` are valid in cycle 3.
- Back-to-back: the next winner is chosen in cycle 3, so sustained throughput is 1 access per 3 cycles.
- Worst-case wait for a continuously requesting core is (N-1) transactions ahead of its own, i.e. completion no later than 3N cycles after `req` is first seen in IDLE.
- `mem_addr`/`mem_wdata` are stable throughout ACCESS.

## Test plan
- Reset: assert reset with `req`=4'b1111, then release. Required: all outputs are 0, `core_en`=4'b0000, and the first grant goes to core 0.
- Single load: core 2 loads addr 0x0010, memory returns 0xBEEF. Required: `mem_re`=1 only in cycle 1 with `mem_addr`=0x0010. In cycle 3, `done`=4'b0100, `rdata`=0xBEEF, `core_en[2]`=1.
- Single store: core 1 stores 0x1234 to 0x0020. Required: `mem_we`=1 for one cycle with `mem_addr`=0x0020 and `mem_wdata`=0x1234, then `done`=4'b0010, and `rdata` holds its previous value.
- Contention: all 4 cores request at once and each holds until its `done`. Required: `done` order is 0,1,2,3, spaced 3 cycles apart. `core_en` rises only for the core that completes.
- Fairness/wrap: core 3 is served, then cores 0 and 3 request again together. Required: core 0 is served before core 3, and no core's `done` repeats while another eligible core is waiting.
- Reset mid-access: assert reset during ACCESS of a store. Required: `mem_we` goes to 0 immediately, no `done` pulse, and the FSM is in IDLE after release.
